// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : Push-button conditioner for two banks of dataWordSize buttons.
//            Each pin passes through a 2-FF synchroniser and a per-bit
//            stability counter clocked by a shared prescaled tick. The block
//            emits clean levels and a one-clock change strobe.
// Options  : `define BTN_PRESS_LATCH_EN adds clrPress, pressH and pressL.
//            These are sticky press flags, and a set wins over a clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int dataWordSize = 8,
  parameter int CLK_DIV      = 50000,
  parameter int DB_COUNT     = 4
) (
  input  logic                    clock,
  input  logic                    nRst,
  input  logic [dataWordSize-1:0] btnHRaw,
  input  logic [dataWordSize-1:0] btnLRaw,
`ifdef BTN_PRESS_LATCH_EN
  input  logic                    clrPress,
  output logic [dataWordSize-1:0] pressH,
  output logic [dataWordSize-1:0] pressL,
`endif
  output logic [dataWordSize-1:0] BTNHDin,
  output logic [dataWordSize-1:0] BTNLDin,
  output logic                    btnChange,
  output logic                    tick
);

  // Both banks are handled as one vector: the high bank is in the upper half.
  localparam int NB = 2 * dataWordSize;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(DB_COUNT + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

  logic [NB-1:0] raw;
  logic [NB-1:0] sync_meta;
  logic [NB-1:0] sync_q;
  logic [NB-1:0] db_q;
  logic [NB-1:0] flip;
  logic [PW-1:0] pre_cnt;

  assign raw     = {btnHRaw, btnLRaw};
  assign BTNHDin = db_q[NB-1:dataWordSize];
  assign BTNLDin = db_q[dataWordSize-1:0];

  // Two-flop synchroniser; this is the only path from the raw pins
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  // Free-running prescaler; tick is the registered terminal-count decode
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
      tick    <= 1'b0;
    end
  end

  // Per-bit stability counters.
  // A bit flips on the tick that completes DB_COUNT mismatched ticks.
  for (genvar i = 0; i < NB; i++) begin : g_bit
    logic [CW-1:0] cnt;

    assign flip[i] = (sync_q[i] != db_q[i]) && tick && (cnt == CNT_LAST);

    // Any agreement clears the count at once, so glitches are rejected between ticks
    always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
        cnt <= '0;
      end else if (sync_q[i] == db_q[i]) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Debounced levels and the change strobe update on the same edge
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      db_q      <= '0;
      btnChange <= 1'b0;
    end else begin
      db_q      <= db_q ^ flip;
      btnChange <= |flip;
    end
  end

`ifdef BTN_PRESS_LATCH_EN
  logic [NB-1:0] press_q;

  assign pressH = press_q[NB-1:dataWordSize];
  assign pressL = press_q[dataWordSize-1:0];

  // Sticky press flags: a debounced 0->1 edge sets the flag, and a set beats a simultaneous clear
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      press_q <= '0;
    end else begin
      press_q <= (clrPress ? '0 : press_q) | (flip & sync_q);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce.sv
// ============================================================================
// Module   : tb_btn_debounce
// Purpose  : Directed self-checking bench for btn_debounce. The main instance
//            uses CLK_DIV=4 and DB_COUNT=3. The boundary instance uses
//            CLK_DIV=1 and DB_COUNT=1. The press-latch steps are built only
//            when BTN_PRESS_LATCH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_debounce;

  logic       clock = 1'b0;
  logic       nRst  = 1'b0;
  logic [7:0] btnHRaw = 8'h00;
  logic [7:0] btnLRaw = 8'h00;
  logic [7:0] BTNHDin;
  logic [7:0] BTNLDin;
  logic       btnChange;
  logic       tick;
`ifdef BTN_PRESS_LATCH_EN
  logic       clrPress = 1'b0;
  logic [7:0] pressH;
  logic [7:0] pressL;
`endif

  logic [7:0] rawH_b = 8'h00;
  logic [7:0] rawL_b = 8'h00;
  logic [7:0] dbH_b;
  logic [7:0] dbL_b;
  logic       chg_b;
  logic       tick_b;

  int n_assert = 0;
  int n_fail   = 0;
  int chg_cnt  = 0;
  int base;
  bit bad;

  always #5 clock = ~clock;

  btn_debounce #(.dataWordSize(8), .CLK_DIV(4), .DB_COUNT(3)) dut (
    .clock    (clock),
    .nRst     (nRst),
    .btnHRaw  (btnHRaw),
    .btnLRaw  (btnLRaw),
`ifdef BTN_PRESS_LATCH_EN
    .clrPress (clrPress),
    .pressH   (pressH),
    .pressL   (pressL),
`endif
    .BTNHDin  (BTNHDin),
    .BTNLDin  (BTNLDin),
    .btnChange(btnChange),
    .tick     (tick)
  );

  btn_debounce #(.dataWordSize(8), .CLK_DIV(1), .DB_COUNT(1)) dut_b (
    .clock    (clock),
    .nRst     (nRst),
    .btnHRaw  (rawH_b),
    .btnLRaw  (rawL_b),
`ifdef BTN_PRESS_LATCH_EN
    .clrPress (1'b0),
    .pressH   (),
    .pressL   (),
`endif
    .BTNHDin  (dbH_b),
    .BTNLDin  (dbL_b),
    .btnChange(chg_b),
    .tick     (tick_b)
  );

  // Count strobe cycles of the main instance; a stuck strobe counts repeatedly
  always @(negedge clock) begin
    if (btnChange === 1'b1) chg_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for a main-instance bank to reach exp, then check the latency window and strobe alignment
  task automatic wait_out(input bit hbank, input logic [7:0] exp, input int lo, input int hi,
                          input string tag);
    int  n;
    bit  found;
    logic [7:0] cur;
    n = 0;
    found = 1'b0;
    while (!found && n < hi + 6) begin
      @(posedge clock);
      #1;
      n++;
      cur = hbank ? BTNHDin : BTNLDin;
      if (cur === exp) found = 1'b1;
    end
    n_assert++;
    assert (found && n >= lo && n <= hi) else begin
      n_fail++;
      $error("FAIL %s_latency: observed %0d clocks (reached=%0d) expected %0d..%0d",
             tag, n, found, lo, hi);
    end
    chk({tag, "_strobe"}, {31'd0, btnChange}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_H", {24'd0, BTNHDin}, 32'h0);
    chk("rst_L", {24'd0, BTNLDin}, 32'h0);
    chk("rst_chg", {31'd0, btnChange}, 32'h0);
    chk("rst_tick", {31'd0, tick}, 32'h0);
    nRst = 1'b1;
    repeat (3) @(negedge clock);
    chk("b_tick_every_clock", {31'd0, tick_b}, 32'h1);

    // Clean press on the high bank
    base = chg_cnt;
    btnHRaw = 8'h81;
    wait_out(1'b1, 8'h81, 11, 14, "pressH");
    repeat (4) @(negedge clock);
    chk("pressH_pulses", chg_cnt - base, 32'd1);

    // Asynchronous reset mid-cycle, with the low bank asserted
    @(posedge clock);
    #3;
    nRst = 1'b0;
    btnLRaw = 8'hFF;
    #1;
    chk("arst_H", {24'd0, BTNHDin}, 32'h0);
    chk("arst_chg", {31'd0, btnChange}, 32'h0);
    chk("arst_tick", {31'd0, tick}, 32'h0);
    repeat (2) @(negedge clock);
    nRst = 1'b1;
    base = chg_cnt;
    wait_out(1'b0, 8'hFF, 11, 14, "rstrel_L");
    chk("rstrel_H_redebounced", {24'd0, BTNHDin}, 32'h81);
    repeat (6) @(negedge clock);
    chk("rstrel_pulses", chg_cnt - base, 32'd1);

    // Release both banks
    btnHRaw = 8'h00;
    wait_out(1'b1, 8'h00, 11, 14, "releaseH");
    @(negedge clock);
    btnLRaw = 8'h00;
    wait_out(1'b0, 8'h00, 11, 14, "releaseL");

    // Bounce on bit0: 3 clocks high, 3 clocks low, then hold high
    bad = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      btnLRaw = (k % 2 == 0) ? 8'h01 : 8'h00;
      repeat (3) begin
        @(posedge clock);
        #1;
        if (BTNLDin !== 8'h00) bad = 1'b1;
      end
    end
    chk("bounce_quiet", {31'd0, bad}, 32'd0);
    @(negedge clock);
    btnLRaw = 8'h01;
    wait_out(1'b0, 8'h01, 11, 14, "bounce_settle");

    // Independence: bit7 press with a one-clock glitch on bit6
    @(negedge clock);
    btnLRaw = 8'hC1;
    @(negedge clock);
    btnLRaw = 8'h81;
    wait_out(1'b0, 8'h81, 10, 13, "indep");
    repeat (16) @(negedge clock);
    chk("indep_hold", {24'd0, BTNLDin}, 32'h81);

    // Boundary instance: output follows the pin exactly three clocks later
    @(negedge clock);
    rawL_b = 8'h5A;
    repeat (2) @(posedge clock);
    #1;
    chk("b_follow_2clk", {24'd0, dbL_b}, 32'h00);
    @(posedge clock);
    #1;
    chk("b_follow_3clk", {24'd0, dbL_b}, 32'h5A);
    chk("b_follow_strobe", {31'd0, chg_b}, 32'h1);
    @(negedge clock);
    rawH_b = 8'h08;
    @(negedge clock);
    rawH_b = 8'h00;
    @(posedge clock);
    #1;
    chk("b_pulse_2clk", {24'd0, dbH_b}, 32'h00);
    @(posedge clock);
    #1;
    chk("b_pulse_3clk", {24'd0, dbH_b}, 32'h08);
    @(posedge clock);
    #1;
    chk("b_pulse_4clk", {24'd0, dbH_b}, 32'h00);

`ifdef BTN_PRESS_LATCH_EN
    // Sticky press flags
    @(negedge clock);
    clrPress = 1'b1;
    @(negedge clock);
    clrPress = 1'b0;
    chk("latch_clearedL", {24'd0, pressL}, 32'h00);
    chk("latch_clearedH", {24'd0, pressH}, 32'h00);
    btnLRaw = 8'h85;
    wait_out(1'b0, 8'h85, 11, 14, "latch_press");
    chk("latch_set", {24'd0, pressL}, 32'h04);
    @(negedge clock);
    btnLRaw = 8'h81;
    wait_out(1'b0, 8'h81, 11, 14, "latch_release");
    chk("latch_persist", {24'd0, pressL}, 32'h04);
    @(negedge clock);
    clrPress = 1'b1;
    btnLRaw = 8'h89;
    wait_out(1'b0, 8'h89, 11, 14, "latch_setwins");
    clrPress = 1'b0;
    chk("latch_setwins_val", {24'd0, pressL}, 32'h08);
    @(posedge clock);
    #1;
    chk("latch_setwins_hold", {24'd0, pressL}, 32'h08);
`endif

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
